braille_session_ctrl: RTL and testbench
=======================================

Name: braille_session_ctrl

Overview:
- Sequences one training session once a mode has been selected.
- Consumes the one-hot mode flags l_m (learn), a_m (assess) and g_m (game).
- Steps a character index through the lesson set and fetches each expected 6-dot Braille cell from an external pattern ROM.
- Captures the user's dot entry, judges it and keeps the score.
- Sits between the mode selection stage and the display/feedback logic.

Parameters:
- NUM_CHARS, 26: characters per session; legal range 1..2^IDX_W.
- IDX_W, 5: width of char_idx.
- SCORE_W, 6: width of score.
- TIMEOUT_CYC, 1000: per-character answer window in game mode, in clk cycles; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- l_m  in  1  learn mode flag.
- a_m  in  1  assess mode flag.
- g_m  in  1  game mode flag.
- start  in  1  session start request; level-sampled in IDLE/DONE.
- dots_in  in  6  user Braille cell entry.
- submit  in  1  entry-valid strobe; one cycle.
- exp_dots  in  6  ROM data for char_idx; combinational, valid in the same cycle.
- char_idx  out  IDX_W  current character / ROM address.
- score  out  SCORE_W  count of correct answers.
- busy  out  1  session in progress.
- correct  out  1  one-cycle pulse: entry matched.
- wrong  out  1  one-cycle pulse: entry mismatched or timed out.
- timeout  out  1  one-cycle pulse: game-mode window expired.
- done  out  1  session complete.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal mode/attempt/timer registers 0.
- State IDLE:
  - Leave only when start=1 and exactly one of l_m/a_m/g_m is 1. Zero-hot or multi-hot mode flags: start is ignored.
  - On leaving: latch the mode; char_idx=0, score=0, attempts=0; go to PRESENT.
- State PRESENT (1 cycle): busy=1; register exp_dots into exp_q; clear timer; go to WAIT_IN.
- State WAIT_IN:
  - submit=1: capture dots_in into ent_q; go to CHECK.
  - Game mode only: timer increments each cycle. If timer==TIMEOUT_CYC-1 and submit=0: go to FEEDBACK with a miss, and pulse timeout and wrong.
  - submit and expiry in the same cycle: submit wins.
- State CHECK (1 cycle): match = (ent_q == exp_q), all 6 bits; go to FEEDBACK.
- State FEEDBACK (1 cycle): exactly one of correct/wrong is high this cycle.
  - Submit latency: submit sampled at edge N gives correct/wrong high in the cycle after edge N+2.
- Learn mode:
  - Correct: advance.
  - Wrong: attempts increments, saturating at 3; return to PRESENT with the same char_idx; score unchanged.
  - attempts clears on advance.
- Assess and game modes:
  - Correct: score increments, saturating at 2^SCORE_W-1.
  - Always advance.
- Advance: if char_idx==NUM_CHARS-1, go to DONE; otherwise char_idx+1 and go to PRESENT.
- State DONE:
  - busy=0, done=1; score and char_idx hold.
  - A valid start (same rule as IDLE) clears done and restarts.
- submit outside WAIT_IN is ignored.
- Mode-change abort:
  - Applies when busy=1 and {l_m,a_m,g_m} differs from the latched mode.
  - Next state is IDLE; busy=0; done stays 0; score and char_idx hold; no correct/wrong pulse.
  - Abort has priority over FEEDBACK.
- Mid-operation reset returns immediately to the reset values above.

Optional Feature:
- HINT_EN defined:
  - Adds output hint_dots (6 bits), registered.
  - In learn mode, when in WAIT_IN with attempts>=2: hint_dots=exp_q. Otherwise 0.
  - Reset value 0.
- HINT_EN not defined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Learn, 2 attempts: l_m=1, start; char 0 exp 6'b000001; submit 6'b000011 then 6'b000001 -> wrong, then correct 2 cycles after each submit; char_idx 0 -> 1; score=0.
- Assess, full run: NUM_CHARS=4; a_m=1; answers correct, wrong, correct, correct -> score=3; done=1 and busy=0 after the 4th FEEDBACK.
- Game timeout: g_m=1, TIMEOUT_CYC=8; no submit -> timeout and wrong pulse 8 cycles after entering WAIT_IN; char_idx 0 -> 1. Submit on the expiry cycle -> judged normally, no timeout.
- Invalid start: l_m=a_m=1, start=1 -> stays IDLE, busy=0. Start in CHECK/FEEDBACK ignored.
- Abort: a_m drops during WAIT_IN at char 2 with score 1 -> IDLE next cycle; score=1, char_idx=2, done=0, no pulses.
- Async reset mid-WAIT_IN -> all outputs 0 without a clock edge. With HINT_EN: learn, two wrongs -> hint_dots=exp cell during WAIT_IN.

Source files
------------

// File: rtl/braille_session_ctrl.sv
// Session sequencer for the Braille trainer: steps through the lesson set, judges dot entries and keeps score.
// Optional macro HINT_EN adds a registered hint_dots output that shows the expected cell in learn mode.
module braille_session_ctrl #(
  parameter int NUM_CHARS   = 26,
  parameter int IDX_W       = 5,
  parameter int SCORE_W     = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               l_m,
  input  logic               a_m,
  input  logic               g_m,
  input  logic               start,
  input  logic [5:0]         dots_in,
  input  logic               submit,
  input  logic [5:0]         exp_dots,
  output logic [IDX_W-1:0]   char_idx,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               correct,
  output logic               wrong,
  output logic               timeout,
`ifdef HINT_EN
  output logic [5:0]         hint_dots,
`endif
  output logic               done
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESENT  = 3'd1,
    S_WAIT_IN  = 3'd2,
    S_CHECK    = 3'd3,
    S_FEEDBACK = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [1:0]         attempts_q, attempts_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [5:0]         exp_q, exp_d;
  logic [5:0]         ent_q, ent_d;
  logic               match_q, match_d;
  logic               miss_q, miss_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               busy_q, busy_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;
  logic               timeout_q, timeout_d;
  logic               done_q, done_d;
  logic [5:0]         hint_q, hint_d;

  logic [2:0] mode_s;
  logic       onehot_s, in_session_s, abort_s, last_s, expire_s;
  logic       learn_s, game_s, timeout_evt_s;

  assign mode_s       = {l_m, a_m, g_m};
  assign onehot_s     = (mode_s == 3'b100) || (mode_s == 3'b010) || (mode_s == 3'b001);
  assign in_session_s = (state_q == S_PRESENT) || (state_q == S_WAIT_IN) ||
                        (state_q == S_CHECK)   || (state_q == S_FEEDBACK);
  // Any change of the mode flags while a session runs abandons it
  assign abort_s      = in_session_s && (mode_s != mode_q);
  assign last_s       = (idx_q == IDX_W'(NUM_CHARS - 1));
  assign expire_s     = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign learn_s      = mode_q[2];
  assign game_s       = mode_q[0];
  assign timeout_evt_s = !abort_s && (state_q == S_WAIT_IN) && !submit && game_s && expire_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 3'b000;
      attempts_q <= 2'd0;
      timer_q    <= '0;
      exp_q      <= 6'd0;
      ent_q      <= 6'd0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
      idx_q      <= '0;
      score_q    <= '0;
      busy_q     <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      hint_q     <= 6'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      attempts_q <= attempts_d;
      timer_q    <= timer_d;
      exp_q      <= exp_d;
      ent_q      <= ent_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      busy_q     <= busy_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      hint_q     <= hint_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    exp_d      = exp_q;
    ent_d      = ent_q;
    match_d    = match_q;
    miss_d     = miss_q;
    idx_d      = idx_q;
    score_d    = score_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && onehot_s) begin
            mode_d     = mode_s;
            idx_d      = '0;
            score_d    = '0;
            attempts_d = 2'd0;
            state_d    = S_PRESENT;
          end else begin
            state_d = state_q;
          end
        end
        S_PRESENT: begin
          exp_d   = exp_dots;
          timer_d = '0;
          match_d = 1'b0;
          miss_d  = 1'b0;
          state_d = S_WAIT_IN;
        end
        S_WAIT_IN: begin
          if (submit) begin
            ent_d   = dots_in;
            state_d = S_CHECK;
          end else if (game_s && expire_s) begin
            miss_d  = 1'b1;
            state_d = S_FEEDBACK;
          end else if (game_s) begin
            timer_d = timer_q + TMR_W'(1);
          end else begin
            timer_d = timer_q;
          end
        end
        S_CHECK: begin
          match_d = (ent_q == exp_q);
          state_d = S_FEEDBACK;
        end
        S_FEEDBACK: begin
          // Learn mode repeats a missed character; other modes always move on
          if (learn_s && !match_q) begin
            if (attempts_q != 2'd3) begin
              attempts_d = attempts_q + 2'd1;
            end else begin
              attempts_d = attempts_q;
            end
            state_d = S_PRESENT;
          end else begin
            if (!learn_s && match_q && !miss_q && (score_q != {SCORE_W{1'b1}})) begin
              score_d = score_q + SCORE_W'(1);
            end else begin
              score_d = score_q;
            end
            attempts_d = 2'd0;
            if (last_s) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_PRESENT;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output values, registered alongside the state
  always_comb begin
    busy_d    = (state_d == S_PRESENT) || (state_d == S_WAIT_IN) ||
                (state_d == S_CHECK)   || (state_d == S_FEEDBACK);
    done_d    = (state_d == S_DONE);
    correct_d = !abort_s && (state_q == S_FEEDBACK) && !miss_q && match_q;
    wrong_d   = (!abort_s && (state_q == S_FEEDBACK) && !miss_q && !match_q) || timeout_evt_s;
    timeout_d = timeout_evt_s;
    if ((state_d == S_WAIT_IN) && learn_s && (attempts_d >= 2'd2)) begin
      hint_d = exp_d;
    end else begin
      hint_d = 6'd0;
    end
  end

  assign char_idx = idx_q;
  assign score    = score_q;
  assign busy     = busy_q;
  assign correct  = correct_q;
  assign wrong    = wrong_q;
  assign timeout  = timeout_q;
  assign done     = done_q;
`ifdef HINT_EN
  assign hint_dots = hint_q;
`endif

endmodule

// File: tb/tb_braille_session_ctrl.sv
// Scoreboard bench for braille_session_ctrl: four-character lesson, eight-cycle game window.
module tb_braille_session_ctrl;
  localparam int NC = 4;
  localparam int IW = 5;
  localparam int SW = 6;
  localparam int TO = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic l_m = 1'b0, a_m = 1'b0, g_m = 1'b0, start = 1'b0, submit = 1'b0;
  logic [5:0] dots_in = 6'd0;
  logic [5:0] exp_dots;
  logic [IW-1:0] char_idx;
  logic [SW-1:0] score;
  logic busy, correct, wrong, timeout, done;
`ifdef HINT_EN
  logic [5:0] hint_dots;
`endif

  logic [5:0] rom [0:NC-1];
  assign exp_dots = (int'(char_idx) < NC) ? rom[char_idx] : 6'd0;

  typedef struct {
    logic c;
    logic w;
    int   idx;
    int   sc;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  braille_session_ctrl #(.NUM_CHARS(NC), .IDX_W(IW), .SCORE_W(SW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .l_m(l_m), .a_m(a_m), .g_m(g_m), .start(start),
    .dots_in(dots_in), .submit(submit), .exp_dots(exp_dots),
    .char_idx(char_idx), .score(score), .busy(busy), .correct(correct),
    .wrong(wrong), .timeout(timeout),
`ifdef HINT_EN
    .hint_dots(hint_dots),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [2:0] m);
    {l_m, a_m, g_m} = m;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; submit = 1'b0; dots_in = 6'd0; set_mode(3'b000);
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Leaves the bench one cycle into WAIT_IN
  task automatic begin_session(input logic [2:0] m);
    set_mode(m); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic collect(output logic c, output logic w, output logic t, output int lat);
    bit found = 0;
    c = 1'b0; w = 1'b0; t = 1'b0; lat = -1;
    for (int k = 1; k <= 12; k++) begin
      if (!found) begin
        tick();
        if (correct || wrong || timeout) begin
          c = correct; w = wrong; t = timeout; lat = k; found = 1;
        end
      end
    end
  endtask

  task automatic answer(input logic [5:0] d, output logic c, output logic w, output logic t, output int lat);
    dots_in = d; submit = 1'b1;
    tick();
    submit = 1'b0;
    collect(c, w, t, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    total++;
    if ({busy, done, correct, wrong, timeout, char_idx, score} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b c=%b w=%b t=%b idx=%0d score=%0d required all 0",
               busy, done, correct, wrong, timeout, char_idx, score);
    end
  endtask

  task automatic test_learn();
    exp_t e; logic c, w, t; int lat;
    do_reset();
    begin_session(3'b100);
    e.c = 1'b0; e.w = 1'b1; e.idx = 0; e.sc = 0; sbq.push_back(e);
    answer(6'b000011, c, w, t, lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 2 || c !== e.c || w !== e.w || int'(char_idx) != e.idx || int'(score) != e.sc) begin
      bad++;
      $display("FAIL learn_wrong: lat=%0d c=%b w=%b idx=%0d score=%0d required lat=2 c=%b w=%b idx=%0d score=%0d",
               lat, c, w, char_idx, score, e.c, e.w, e.idx, e.sc);
    end
    tick();
    e.c = 1'b1; e.w = 1'b0; e.idx = 1; e.sc = 0; sbq.push_back(e);
    answer(6'b000001, c, w, t, lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 2 || c !== e.c || w !== e.w || int'(char_idx) != e.idx || int'(score) != e.sc) begin
      bad++;
      $display("FAIL learn_right: lat=%0d c=%b w=%b idx=%0d score=%0d required lat=2 c=%b w=%b idx=%0d score=%0d",
               lat, c, w, char_idx, score, e.c, e.w, e.idx, e.sc);
    end
  endtask

  task automatic test_assess_full();
    exp_t e; logic c, w, t; int lat; int sc = 0;
    bit ok [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [5:0] d;
    do_reset();
    begin_session(3'b010);
    for (int i = 0; i < NC; i++) begin
      if (i > 0) tick();
      d = ok[i] ? rom[i] : (rom[i] ^ 6'b000100);
      if (ok[i]) sc++;
      e.c = ok[i]; e.w = !ok[i]; e.idx = (i == NC - 1) ? i : i + 1; e.sc = sc; sbq.push_back(e);
      answer(d, c, w, t, lat);
      e = sbq.pop_front();
      total++;
      if (lat !== 2 || c !== e.c || w !== e.w || int'(char_idx) != e.idx || int'(score) != e.sc) begin
        bad++;
        $display("FAIL assess_char%0d: lat=%0d c=%b w=%b idx=%0d score=%0d required lat=2 c=%b w=%b idx=%0d score=%0d",
                 i, lat, c, w, char_idx, score, e.c, e.w, e.idx, e.sc);
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || score !== 6'd3) begin
      bad++;
      $display("FAIL assess_done: done=%b busy=%b score=%0d required done=1 busy=0 score=3", done, busy, score);
    end
    set_mode(3'b001); start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || char_idx !== 5'd0 || score !== 6'd0) begin
      bad++;
      $display("FAIL restart_from_done: done=%b busy=%b idx=%0d score=%0d required 0 1 0 0", done, busy, char_idx, score);
    end
  endtask

  task automatic test_game_timeout();
    exp_t e; logic c, w, t; int lat;
    do_reset();
    begin_session(3'b001);
    for (int k = 1; k <= TO; k++) begin
      tick();
      total++;
      if (k < TO) begin
        if (timeout !== 1'b0 || wrong !== 1'b0 || correct !== 1'b0) begin
          bad++;
          $display("FAIL timeout_early: cycle=%0d t=%b w=%b c=%b required 0 0 0", k, timeout, wrong, correct);
        end
      end else begin
        if (timeout !== 1'b1 || wrong !== 1'b1 || correct !== 1'b0 || char_idx !== 5'd0) begin
          bad++;
          $display("FAIL timeout_pulse: t=%b w=%b c=%b idx=%0d required 1 1 0 idx=0", timeout, wrong, correct, char_idx);
        end
      end
    end
    tick();
    total++;
    if (char_idx !== 5'd1 || score !== 6'd0 || wrong !== 1'b0) begin
      bad++;
      $display("FAIL timeout_advance: idx=%0d score=%0d w=%b required idx=1 score=0 w=0", char_idx, score, wrong);
    end
    tick();
    for (int k = 1; k < TO; k++) tick();
    e.c = 1'b1; e.w = 1'b0; e.idx = 2; e.sc = 1; sbq.push_back(e);
    answer(rom[1], c, w, t, lat);
    e = sbq.pop_front();
    total++;
    if (lat !== 2 || c !== e.c || w !== e.w || t !== 1'b0 || int'(char_idx) != e.idx || int'(score) != e.sc) begin
      bad++;
      $display("FAIL submit_on_expiry: lat=%0d c=%b w=%b t=%b idx=%0d score=%0d required lat=2 c=%b w=%b t=0 idx=%0d score=%0d",
               lat, c, w, t, char_idx, score, e.c, e.w, e.idx, e.sc);
    end
  endtask

  task automatic test_invalid_start();
    exp_t e; logic c, w, t; int lat;
    do_reset();
    set_mode(3'b110); start = 1'b1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || char_idx !== 5'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL multi_hot_start: busy=%b idx=%0d done=%b required 0 0 0", busy, char_idx, done);
    end
    set_mode(3'b000);
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_hot_start: busy=%b required 0", busy);
    end
    begin_session(3'b100);
    e.c = 1'b1; e.w = 1'b0; e.idx = 1; e.sc = 0; sbq.push_back(e);
    dots_in = rom[0]; submit = 1'b1;
    tick();
    submit = 1'b0; start = 1'b1;
    collect(c, w, t, lat);
    start = 1'b0;
    e = sbq.pop_front();
    total++;
    if (lat !== 2 || c !== e.c || w !== e.w || int'(char_idx) != e.idx || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_while_busy: lat=%0d c=%b w=%b idx=%0d busy=%b required lat=2 c=%b w=%b idx=%0d busy=1",
               lat, c, w, char_idx, busy, e.c, e.w, e.idx);
    end
  endtask

  task automatic test_abort();
    exp_t e; logic c, w, t; int lat;
    do_reset();
    begin_session(3'b010);
    e.c = 1'b1; e.w = 1'b0; e.idx = 1; e.sc = 1; sbq.push_back(e);
    answer(rom[0], c, w, t, lat);
    e = sbq.pop_front();
    total++;
    if (c !== e.c || w !== e.w || int'(char_idx) != e.idx || int'(score) != e.sc) begin
      bad++;
      $display("FAIL abort_setup0: c=%b w=%b idx=%0d score=%0d required c=%b w=%b idx=%0d score=%0d",
               c, w, char_idx, score, e.c, e.w, e.idx, e.sc);
    end
    tick();
    e.c = 1'b0; e.w = 1'b1; e.idx = 2; e.sc = 1; sbq.push_back(e);
    answer(rom[1] ^ 6'b100000, c, w, t, lat);
    e = sbq.pop_front();
    total++;
    if (c !== e.c || w !== e.w || int'(char_idx) != e.idx || int'(score) != e.sc) begin
      bad++;
      $display("FAIL abort_setup1: c=%b w=%b idx=%0d score=%0d required c=%b w=%b idx=%0d score=%0d",
               c, w, char_idx, score, e.c, e.w, e.idx, e.sc);
    end
    tick();
    set_mode(3'b000);
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || score !== 6'd1 || char_idx !== 5'd2 ||
          correct !== 1'b0 || wrong !== 1'b0 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL abort_cycle%0d: busy=%b done=%b score=%0d idx=%0d c=%b w=%b t=%b required 0 0 1 2 0 0 0",
                 k, busy, done, score, char_idx, correct, wrong, timeout);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e; logic c, w, t; int lat;
    do_reset();
    begin_session(3'b010);
    e.c = 1'b1; e.w = 1'b0; e.idx = 1; e.sc = 1; sbq.push_back(e);
    answer(rom[0], c, w, t, lat);
    e = sbq.pop_front();
    total++;
    if (c !== e.c || int'(char_idx) != e.idx || int'(score) != e.sc) begin
      bad++;
      $display("FAIL areset_setup: c=%b idx=%0d score=%0d required c=%b idx=%0d score=%0d",
               c, char_idx, score, e.c, e.idx, e.sc);
    end
    tick();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({busy, done, correct, wrong, timeout, char_idx, score} !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b c=%b w=%b t=%b idx=%0d score=%0d required all 0",
               busy, done, correct, wrong, timeout, char_idx, score);
    end
    rst = 1'b1;
    tick();
  endtask

`ifdef HINT_EN
  task automatic test_hint();
    logic c, w, t; int lat;
    do_reset();
    begin_session(3'b100);
    answer(6'b111000, c, w, t, lat);
    tick();
    total++;
    if (hint_dots !== 6'd0) begin
      bad++;
      $display("FAIL hint_after_one: hint=%b required 000000", hint_dots);
    end
    answer(6'b111000, c, w, t, lat);
    tick();
    total++;
    if (hint_dots !== rom[0]) begin
      bad++;
      $display("FAIL hint_after_two: hint=%b required %b", hint_dots, rom[0]);
    end
  endtask
`endif

  initial begin
    rom[0] = 6'b000001;
    rom[1] = 6'b101010;
    rom[2] = 6'b110011;
    rom[3] = 6'b111111;
    test_reset();
    test_learn();
    test_assess_full();
    test_game_timeout();
    test_invalid_start();
    test_abort();
    test_async_reset();
`ifdef HINT_EN
    test_hint();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
